// File: rtl/posit_to_float_if.sv
// Handshake/data bundle for posit_to_float: posit operand in, IEEE-754 single plus flags out.
interface posit_to_float_if;
  logic [31:0] in1;
  logic        start;
  logic [31:0] result;
  logic        nar;
  logic        zero;
  logic        inexact;
  logic        done;

  modport master (
    output in1, start,
    input  result, nar, zero, inexact, done
  );

  modport slave (
    input  in1, start,
    output result, nar, zero, inexact, done
  );
endinterface

// File: rtl/posit_to_float.sv
// Pipelined posit<32,2> to IEEE-754 single converter, latency 3 enabled cycles.
// Define POSIT2FLOAT_RNE_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module posit_to_float #(
  parameter int unsigned NBITS = 32,
  parameter int unsigned ES    = 2
) (
  input logic            clk,
  input logic            reset_n,
  input logic            ce,
  posit_to_float_if.slave io
);

  // Stage 0
  logic [NBITS-1:0] in_q;
  logic             v0_q;

  // Stage 1
  logic        s1_sign_q, s1_zero_q, s1_nar_q, v1_q;
  logic [30:0] s1_abs_q;
  logic [5:0]  s1_run_q;
  logic [7:0]  s1_k_q;

  // Stage 2
  logic        s2_sign_q, s2_zero_q, s2_nar_q, v2_q;
  logic [7:0]  s2_scale_q;
  logic [26:0] s2_frac_q;

  // Outputs
  logic [31:0] result_q;
  logic        nar_q, zero_q, inexact_q, done_q;

  // Stage 1: magnitude, specials, regime run length
  logic [30:0] abs_d;
  logic        run_bit_d, running;
  logic [5:0]  run_len_d;
  logic [7:0]  k_d;
  logic        zero_d, nar_d;

  always_comb begin
    abs_d = in_q[30:0];
    if (in_q[31]) abs_d = -in_q[30:0];
    run_bit_d = abs_d[30];
    run_len_d = '0;
    running   = 1'b1;
    for (int i = 30; i >= 0; i--) begin
      if (running && (abs_d[i] == run_bit_d)) run_len_d = run_len_d + 6'd1;
      else running = 1'b0;
    end
    // k kept as 8-bit two's complement; scale arithmetic below is modular
    k_d    = run_bit_d ? (8'(run_len_d) - 8'd1) : (8'd0 - 8'(run_len_d));
    zero_d = (in_q == '0);
    nar_d  = (in_q == {1'b1, {(NBITS-1){1'b0}}});
  end

  // Stage 2: strip regime and terminator; a full-length run shifts everything out
  logic [30:0] shifted_d;
  logic [1:0]  exp_bits_d;
  logic [26:0] frac_d;
  logic [7:0]  scale_d;

  always_comb begin
    shifted_d  = s1_abs_q << (s1_run_q + 6'd1);
    exp_bits_d = shifted_d[30:29];
    frac_d     = 27'(shifted_d >> 2);
    scale_d    = (s1_k_q << ES) + {6'b0, exp_bits_d};
  end

  // Stage 3: bias, round, specials
  logic [7:0]  bexp_d;
  logic [22:0] mant_d;
  logic        guard_d, sticky_d, inexact_d;
  logic [31:0] result_d;
`ifdef POSIT2FLOAT_RNE_EN
  logic [23:0] mant_sum_d;
`endif

  always_comb begin
    bexp_d    = s2_scale_q + 8'd127;
    mant_d    = s2_frac_q[26:4];
    guard_d   = s2_frac_q[3];
    sticky_d  = |s2_frac_q[2:0];
    inexact_d = guard_d | sticky_d;
`ifdef POSIT2FLOAT_RNE_EN
    mant_sum_d = {1'b0, mant_d} + 24'(guard_d & (sticky_d | mant_d[0]));
    result_d   = {s2_sign_q, bexp_d + 8'(mant_sum_d[23]), mant_sum_d[22:0]};
`else
    result_d   = {s2_sign_q, bexp_d, mant_d};
`endif
    if (s2_zero_q) begin
      result_d  = 32'h0000_0000;
      inexact_d = 1'b0;
    end
    if (s2_nar_q) begin
      result_d  = 32'h7FC0_0000;
      inexact_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      in_q       <= '0;
      v0_q       <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_nar_q   <= 1'b0;
      s1_abs_q   <= '0;
      s1_run_q   <= '0;
      s1_k_q     <= '0;
      v1_q       <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_nar_q   <= 1'b0;
      s2_scale_q <= '0;
      s2_frac_q  <= '0;
      v2_q       <= 1'b0;
      result_q   <= '0;
      nar_q      <= 1'b0;
      zero_q     <= 1'b0;
      inexact_q  <= 1'b0;
      done_q     <= 1'b0;
    end else if (ce) begin
      in_q       <= io.start ? io.in1 : '0;
      v0_q       <= io.start;
      s1_sign_q  <= in_q[NBITS-1];
      s1_zero_q  <= zero_d;
      s1_nar_q   <= nar_d;
      s1_abs_q   <= abs_d;
      s1_run_q   <= run_len_d;
      s1_k_q     <= k_d;
      v1_q       <= v0_q;
      s2_sign_q  <= s1_sign_q;
      s2_zero_q  <= s1_zero_q;
      s2_nar_q   <= s1_nar_q;
      s2_scale_q <= scale_d;
      s2_frac_q  <= frac_d;
      v2_q       <= v1_q;
      done_q     <= v2_q;
      // Results only move on a valid slot so idle cycles keep the last answer visible
      if (v2_q) begin
        result_q  <= result_d;
        nar_q     <= s2_nar_q;
        zero_q    <= s2_zero_q;
        inexact_q <= inexact_d;
      end
    end
  end

  assign io.result  = result_q;
  assign io.nar     = nar_q;
  assign io.zero    = zero_q;
  assign io.inexact = inexact_q;
  assign io.done    = done_q;

endmodule

// File: tb/tb_posit_to_float.sv
// Self-checking bench for posit_to_float: real-valued posit decode model plus a timing scoreboard.
module tb_posit_to_float;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ce = 1'b0;
  always #5 clk = ~clk;

  posit_to_float_if bus ();

  posit_to_float dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .io      (bus)
  );

  typedef struct {
    logic [31:0] p;
    int unsigned en;
    logic        has_k;
    logic [31:0] k;
  } item_t;

  item_t       q[$];
  int unsigned en_cnt = 0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_res = '0;
  logic        exp_nar = 1'b0, exp_zero = 1'b0, exp_inx = 1'b0, exp_done = 1'b0;
  logic        cur_has_k = 1'b0;
  logic [31:0] cur_k = '0;

`ifdef POSIT2FLOAT_RNE_EN
  localparam logic [31:0] RoundK = 32'h3F80_0002;
`else
  localparam logic [31:0] RoundK = 32'h3F80_0001;
`endif

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) repeat (n) r = r * 2.0;
    else repeat (-n) r = r / 2.0;
    return r;
  endfunction

  // Decode posit to a real value, then encode that value as a binary32.
  function automatic void ref_model(input logic [31:0] p, output logic [31:0] r,
                                    output logic n, output logic z, output logic x);
    logic [31:0] a;
    logic        s, b;
    int          i, m, k, e, xe;
    real         f, w, v, ms, rem;
    longint      mi;
    n = 1'b0; z = 1'b0; x = 1'b0; r = '0;
    if (p == 32'h0) begin
      z = 1'b1;
      return;
    end
    if (p == 32'h8000_0000) begin
      n = 1'b1;
      r = 32'h7FC0_0000;
      return;
    end
    s = p[31];
    a = s ? -p : p;
    i = 30; b = a[30]; m = 0;
    while (i >= 0) begin
      if (a[i] != b) break;
      m++;
      i--;
    end
    i--;
    k = b ? m - 1 : -m;
    e = 0;
    for (int j = 0; j < 2; j++) begin
      e = e * 2 + ((i >= 0) ? int'(a[i]) : 0);
      i--;
    end
    f = 0.0; w = 0.5;
    while (i >= 0) begin
      if (a[i]) f = f + w;
      w = w / 2.0;
      i--;
    end
    v = (1.0 + f) * pow2(4 * k + e);
    xe = 0;
    while (v >= 2.0) begin v = v / 2.0; xe++; end
    while (v < 1.0) begin v = v * 2.0; xe--; end
    ms  = (v - 1.0) * 8388608.0;
    mi  = longint'($floor(ms));
    rem = ms - real'(mi);
    x   = (rem != 0.0);
`ifdef POSIT2FLOAT_RNE_EN
    if (rem > 0.5 || (rem == 0.5 && mi[0])) mi++;
    if (mi == 64'd8388608) begin mi = 0; xe++; end
`endif
    r = {s, 8'(xe + 127), 23'(mi)};
  endfunction

  // One clock: account the edge, then compare all outputs against the expected state.
  task automatic step();
    item_t       it;
    logic [31:0] r;
    logic        n, z, x;
    @(posedge clk);
    #1;
    if (!reset_n) begin
      q.delete();
      exp_res = '0; exp_nar = 1'b0; exp_zero = 1'b0; exp_inx = 1'b0; exp_done = 1'b0;
    end else if (ce) begin
      en_cnt++;
      exp_done = (q.size() > 0) && (en_cnt - q[0].en == 3);
      if (exp_done) begin
        it = q.pop_front();
        ref_model(it.p, r, n, z, x);
        exp_res = r; exp_nar = n; exp_zero = z; exp_inx = x;
        if (it.has_k) check_val("directed", bus.result, it.k);
      end
      if (bus.start) begin
        it.p = bus.in1; it.en = en_cnt; it.has_k = cur_has_k; it.k = cur_k;
        q.push_back(it);
      end
    end
    check_val("done", 32'(bus.done), 32'(exp_done));
    check_val("result", bus.result, exp_res);
    check_val("nar", 32'(bus.nar), 32'(exp_nar));
    check_val("zero", 32'(bus.zero), 32'(exp_zero));
    check_val("inexact", 32'(bus.inexact), 32'(exp_inx));
  endtask

  task automatic drive(input logic [31:0] p, input logic s, input logic c = 1'b1,
                       input logic has_k = 1'b0, input logic [31:0] k = '0);
    bus.in1 = p; bus.start = s; ce = c; cur_has_k = has_k; cur_k = k;
    step();
  endtask

  logic [31:0] sp [6];

  initial begin
    sp[0] = 32'h0000_0000; sp[1] = 32'h8000_0000; sp[2] = 32'h7FFF_FFFF;
    sp[3] = 32'h8000_0001; sp[4] = 32'h0000_0001; sp[5] = 32'hFFFF_FFFF;
    bus.in1 = '0; bus.start = 1'b0;

    // Reset wins over ce = 0
    reset_n = 1'b0;
    drive(32'h0, 1'b0, 1'b0);
    drive(32'h0, 1'b0, 1'b1);
    reset_n = 1'b1;

    // Back-to-back directed stream
    drive(32'h4000_0000, 1'b1, 1'b1, 1'b1, 32'h3F80_0000);
    drive(32'hC000_0000, 1'b1, 1'b1, 1'b1, 32'hBF80_0000);
    drive(32'h4800_0000, 1'b1, 1'b1, 1'b1, 32'h4000_0000);
    drive(32'h3800_0000, 1'b1, 1'b1, 1'b1, 32'h3F00_0000);
    drive(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 32'h7B80_0000);
    drive(32'h0000_0001, 1'b1, 1'b1, 1'b1, 32'h0380_0000);
    drive(32'h8000_0001, 1'b1, 1'b1, 1'b1, 32'hFB80_0000);
    drive(32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0000);
    drive(32'h8000_0000, 1'b1, 1'b1, 1'b1, 32'h7FC0_0000);
    drive(32'h4000_0018, 1'b1, 1'b1, 1'b1, RoundK);
    drive(32'h4000_0008, 1'b1, 1'b1, 1'b1, 32'h3F80_0000);
    repeat (4) drive(32'h0, 1'b0);

    // ce low for 5 cycles in the middle of three starts
    drive(32'h4800_0000, 1'b1);
    drive(32'hC000_0000, 1'b1);
    repeat (5) drive(32'h0, 1'b0, 1'b0);
    drive(32'h3800_0000, 1'b1);
    repeat (5) drive(32'h0, 1'b0);

    // Reset with two conversions in flight, then a fresh one
    drive(32'h4000_0000, 1'b1);
    drive(32'h7FFF_FFFF, 1'b1);
    reset_n = 1'b0;
    drive(32'h0, 1'b0);
    reset_n = 1'b1;
    drive(32'hC000_0000, 1'b1, 1'b1, 1'b1, 32'hBF80_0000);
    repeat (5) drive(32'h0, 1'b0);

    // Randomized traffic with ce gaps
    for (int t = 0; t < 400; t++) begin
      logic [31:0] p;
      p = ($urandom_range(3) == 0) ? sp[$urandom_range(5)] : $urandom;
      drive(p, ($urandom_range(4) != 0), ($urandom_range(7) != 0));
    end
    repeat (8) drive(32'h0, 1'b0);
    check_val("drain", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
